tone_gate: RTL and testbench

TONE_GATE -- requirements
Module: tone_gate

---
 rtl/tone_gate.sv | 158 +++++++++++++++
 tb/tb_tone_gate.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tone_gate.sv
// Gates a divided-clock tone onto the speaker while a debounced key is held, so the
// speaker output only ever starts on a tone rising edge and stops with the tone low.
module tone_gate #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned MIN_HOLD_CYCLES = 5000000,
    parameter int unsigned TONE_TIMEOUT    = 50000000
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       tone_in,
    input  logic       key_in,
    output logic       audio_out,
    output logic       playing,
    output logic [7:0] note_count,
    output logic       stall
);

    typedef enum logic [1:0] {StIdle, StArm, StPlay, StRelease} state_e;

    state_e      r_state;
    state_e      w_state_next;

    logic        r_tone_meta;
    logic        r_tone_s;
    logic        r_tone_prev;
    logic        r_key_meta;
    logic        r_key_s;
    logic        r_key_db;
    logic        r_key_db_prev;
    logic [31:0] r_db_cnt;
    logic [31:0] r_to_cnt;
    logic [31:0] r_hold_cnt;

    logic        w_tone_rise;
    logic        w_key_press;
    logic        w_play_next;
    logic        w_enter_play;
    logic        w_arm_timeout;

    assign w_tone_rise = r_tone_s & ~r_tone_prev;
    assign w_key_press = r_key_db & ~r_key_db_prev;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_tone_meta <= 1'b0;
            r_tone_s    <= 1'b0;
            r_tone_prev <= 1'b0;
            r_key_meta  <= 1'b0;
            r_key_s     <= 1'b0;
        end else begin
            r_tone_meta <= tone_in;
            r_tone_s    <= r_tone_meta;
            r_tone_prev <= r_tone_s;
            r_key_meta  <= key_in;
            r_key_s     <= r_key_meta;
        end
    end

    // Any sample that agrees with the accepted level restarts the stability count.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt      <= '0;
            r_key_db      <= 1'b0;
            r_key_db_prev <= 1'b0;
        end else begin
            r_key_db_prev <= r_key_db;
            if (r_key_s == r_key_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DEBOUNCE_CYCLES - 32'd1) begin
                r_key_db <= r_key_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_key_press) w_state_next = StArm;
            end
            StArm: begin
                if (w_tone_rise) begin
                    w_state_next = StPlay;
                end else if (!r_key_db) begin
                    w_state_next = StIdle;
                end else if (r_to_cnt == TONE_TIMEOUT - 32'd1) begin
                    w_state_next = StIdle;
                end
            end
            StPlay: begin
                if (!r_key_db && (r_hold_cnt == MIN_HOLD_CYCLES)) w_state_next = StRelease;
            end
            StRelease: begin
                if (w_key_press && r_tone_s) begin
                    w_state_next = StPlay;
                end else if (!r_tone_s) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Leaving ARM for IDLE with the key still down can only be the timeout.
    always_comb begin
        w_play_next   = (w_state_next == StPlay) || (w_state_next == StRelease);
        w_enter_play  = (w_state_next == StPlay) && (r_state != StPlay);
        w_arm_timeout = (r_state == StArm) && (w_state_next == StIdle) && r_key_db;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt   <= '0;
            r_hold_cnt <= '0;
            note_count <= '0;
            stall      <= 1'b0;
            audio_out  <= 1'b0;
            playing    <= 1'b0;
        end else begin
            if ((r_state == StIdle) && w_key_press) begin
                r_to_cnt <= '0;
            end else if (r_state == StArm) begin
                r_to_cnt <= r_to_cnt + 32'd1;
            end

            if (w_enter_play) begin
                r_hold_cnt <= '0;
            end else if ((r_state == StPlay) && (r_hold_cnt != MIN_HOLD_CYCLES)) begin
                r_hold_cnt <= r_hold_cnt + 32'd1;
            end

            if (w_enter_play && (note_count != 8'hFF)) begin
                note_count <= note_count + 8'd1;
            end

            if (w_arm_timeout) begin
                stall <= 1'b1;
            end else if ((r_state == StArm) && w_enter_play) begin
                stall <= 1'b0;
            end

            audio_out <= r_tone_s & w_play_next;
            playing   <= w_play_next;
        end
    end

endmodule

// File: tb/tb_tone_gate.sv
// Random-stimulus bench for tone_gate: every cycle the outputs are compared with a
// behavioural model built directly from the block's rules.
module tb_tone_gate;

    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int TO   = 100;

    localparam int MODE_IDLE    = 0;
    localparam int MODE_ARM     = 1;
    localparam int MODE_PLAY    = 2;
    localparam int MODE_RELEASE = 3;

    logic       clk_in  = 1'b0;
    logic       rst_n   = 1'b0;
    logic       tone_in = 1'b0;
    logic       key_in  = 1'b0;
    logic       audio_out;
    logic       playing;
    logic [7:0] note_count;
    logic       stall;

    int n_checks = 0;
    int n_fails  = 0;

    bit tone_run   = 1'b1;
    int tone_phase = 0;

    // Model state
    bit m_tone_meta, m_tone_s, m_tone_d, m_key_meta, m_key_s, m_key_db, m_key_db_was;
    bit m_audio, m_playing, m_stall;
    int m_run, m_mode, m_wait, m_hold, m_notes;

    tone_gate #(
        .DEBOUNCE_CYCLES(DB),
        .MIN_HOLD_CYCLES(HOLD),
        .TONE_TIMEOUT   (TO)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .tone_in   (tone_in),
        .key_in    (key_in),
        .audio_out (audio_out),
        .playing   (playing),
        .note_count(note_count),
        .stall     (stall)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tone_meta = 0; m_tone_s = 0; m_tone_d = 0;
        m_key_meta = 0; m_key_s = 0; m_key_db = 0; m_key_db_was = 0;
        m_audio = 0; m_playing = 0; m_stall = 0;
        m_run = 0; m_mode = MODE_IDLE; m_wait = 0; m_hold = 0; m_notes = 0;
    endtask

    // One clock edge: decisions use what was visible before the edge, then everything moves.
    task automatic model_step(input bit ti, input bit ki);
        bit rise, press, sounding;
        int nm;
        rise  = m_tone_s && !m_tone_d;
        press = m_key_db && !m_key_db_was;
        nm    = m_mode;
        case (m_mode)
            MODE_IDLE: if (press) begin nm = MODE_ARM; m_wait = 0; end
            MODE_ARM: begin
                if (rise) begin
                    nm = MODE_PLAY; m_hold = 0; m_stall = 0;
                    if (m_notes < 255) m_notes++;
                end else if (!m_key_db) nm = MODE_IDLE;
                else if (m_wait == TO - 1) begin nm = MODE_IDLE; m_stall = 1; end
                else m_wait++;
            end
            MODE_PLAY: begin
                if (!m_key_db && m_hold == HOLD) nm = MODE_RELEASE;
                else if (m_hold < HOLD) m_hold++;
            end
            default: begin
                if (press && m_tone_s) begin
                    nm = MODE_PLAY; m_hold = 0;
                    if (m_notes < 255) m_notes++;
                end else if (!m_tone_s) nm = MODE_IDLE;
            end
        endcase
        sounding  = (nm == MODE_PLAY) || (nm == MODE_RELEASE);
        m_audio   = m_tone_s && sounding;
        m_playing = sounding;
        m_mode    = nm;

        m_key_db_was = m_key_db;
        if (m_key_s != m_key_db) begin
            m_run++;
            if (m_run == DB) begin m_key_db = m_key_s; m_run = 0; end
        end else m_run = 0;

        m_tone_d = m_tone_s; m_tone_s = m_tone_meta; m_tone_meta = ti;
        m_key_s = m_key_meta; m_key_meta = ki;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        if (!rst_n) model_reset();
        else model_step(tone_in, key_in);
        check_eq("audio_out", 32'(audio_out), 32'(m_audio));
        check_eq("playing", 32'(playing), 32'(m_playing));
        check_eq("note_count", 32'(note_count), 32'(m_notes));
        check_eq("stall", 32'(stall), 32'(m_stall));
        tone_phase++;
        tone_in = tone_run && ((tone_phase % 16) < 8);
    endtask

    task automatic hold_key(input bit lvl, input int cycles);
        key_in = lvl;
        repeat (cycles) tick();
    endtask

    initial begin
        model_reset();
        tone_in = 1'b1;
        repeat (4) tick();
        check_eq("reset_audio", 32'(audio_out), 32'd0);
        check_eq("reset_notes", 32'(note_count), 32'd0);
        check_eq("reset_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        hold_key(0, 10);

        // Clean press then release
        hold_key(1, 60);
        hold_key(0, 80);
        check_eq("clean_notes", 32'(note_count), 32'd1);
        check_eq("clean_idle", 32'(playing), 32'd0);

        // Bouncing key never qualifies
        begin
            int left = 30;
            bit lvl = 1'b1;
            while (left > 0) begin
                int len = $urandom_range(1, 3);
                if (len > left) len = left;
                hold_key(lvl, len);
                left -= len;
                lvl = !lvl;
            end
        end
        hold_key(0, 40);
        check_eq("bounce_notes", 32'(note_count), 32'd1);
        check_eq("bounce_audio", 32'(audio_out), 32'd0);

        // Stuck tone -> ARM timeout, then recovery with tone running
        tone_run = 1'b0;
        tone_in  = 1'b0;
        hold_key(1, 150);
        check_eq("stall_set", 32'(stall), 32'd1);
        check_eq("stall_idle", 32'(playing), 32'd0);
        hold_key(0, 20);
        tone_run = 1'b1;
        hold_key(1, 60);
        hold_key(0, 80);
        check_eq("stall_clear", 32'(stall), 32'd0);
        check_eq("stall_notes", 32'(note_count), 32'd2);

        // Short presses at every tone phase
        for (int p = 0; p < 16; p++) begin
            hold_key(0, 1 + p);
            hold_key(1, 6);
            hold_key(0, 60);
        end

        // Re-press shortly after release, landing in or around RELEASE
        for (int t = 0; t < 24; t++) begin
            hold_key(1, 40);
            hold_key(0, $urandom_range(4, 14));
            hold_key(1, 30);
            hold_key(0, 80);
        end

        // Saturation
        for (int n = 0; n < 270; n++) begin
            hold_key(1, 40 + $urandom_range(0, 5));
            hold_key(0, 32);
        end
        check_eq("notes_saturated", 32'(note_count), 32'd255);

        // Asynchronous reset while the tone is sounding
        key_in = 1'b1;
        begin
            int i;
            for (i = 0; i < 80; i++) begin
                tick();
                if (m_audio) break;
            end
        end
        check_eq("pre_reset_audio", 32'(audio_out), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("async_audio", 32'(audio_out), 32'd0);
        check_eq("async_playing", 32'(playing), 32'd0);
        check_eq("async_notes", 32'(note_count), 32'd0);
        check_eq("async_stall", 32'(stall), 32'd0);
        key_in = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        hold_key(0, 10);
        hold_key(1, 60);
        hold_key(0, 80);
        check_eq("post_reset_notes", 32'(note_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
